// File: rtl/nibble_sort_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_sort_pkg
// Purpose  : Shared types and constants for the nibble sort controller:
//            FSM state encoding, default block geometry and the index-width
//            helper used to size the word pointers.
// Ports    : none (package)
// Options  : SORT_SWAP_COUNT_EN (consumed by nibble_sort_ctrl)
// Revision : 1.0 - initial release
// ============================================================================
package nibble_sort_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    // Pointer width for a block of 'depth' words.
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage : nibble_sort_pkg
`default_nettype wire

// File: rtl/nibble_magcomp.sv
`default_nettype none
// ============================================================================
// Module   : nibble_magcomp
// Purpose  : Combinational unsigned magnitude comparator. Exactly one of
//            greater/less/equal is high for any pair of operands.
// Ports    : a_i, b_i        - WIDTH-bit operands
//            greater_o       - a_i >  b_i
//            less_o          - a_i <  b_i
//            equal_o         - a_i == b_i
// Revision : 1.0 - initial release
// ============================================================================
module nibble_magcomp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             greater_o,
    output logic             less_o,
    output logic             equal_o
);

    assign greater_o = (a_i >  b_i);
    assign less_o    = (a_i <  b_i);
    assign equal_o   = (a_i == b_i);

endmodule : nibble_magcomp
`default_nettype wire

// File: rtl/nibble_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_sort_ctrl
// Purpose  : Loads a block of DEPTH words over a valid/ready port, bubble
//            sorts it in place with one shared comparator (one compare per
//            cycle, fixed schedule, stable), then drains it ascending over a
//            valid/ready port.
// Ports    : clk, rst_n            - clock, async active-low reset
//            in_valid_i/in_ready_o/in_data_i    - load port
//            out_valid_o/out_ready_i/out_data_o/out_last_o - drain port
//            busy_o                - high while sorting or draining
//            swap_count_o          - swaps in last sort (option only)
// Options  : SORT_SWAP_COUNT_EN - adds the saturating swap counter and port
// Revision : 1.0 - initial release
// ============================================================================
module nibble_sort_ctrl
    import nibble_sort_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    output logic             busy_o
`ifdef SORT_SWAP_COUNT_EN
    ,
    output logic [7:0]       swap_count_o
`endif
);

    localparam int             IW       = idx_width(DEPTH);
    localparam logic [IW-1:0]  LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0]  LAST_CMP = IW'(DEPTH - 2);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [IW-1:0]     wr_q, rd_q, p_q, i_q;
    logic [IW-1:0]     w_i_nxt;
    logic [WIDTH-1:0]  w_a, w_b;
    logic              w_gt, w_lt, w_eq, w_swap;
    logic              w_in_hs, w_out_hs, w_load_done, w_sort_done;

    // Shared comparator always looks at the current adjacent pair.
    assign w_i_nxt = i_q + 1'b1;
    assign w_a     = mem_q[i_q];
    assign w_b     = mem_q[w_i_nxt];

    nibble_magcomp #(.WIDTH(WIDTH)) u_cmp (
        .a_i       (w_a),
        .b_i       (w_b),
        .greater_o (w_gt),
        .less_o    (w_lt),
        .equal_o   (w_eq)
    );

    // Swap only on a strict greater; equal keeps order, so the sort is stable.
    assign w_swap = (state_q == ST_SORT) && w_gt && !w_lt && !w_eq;

    assign w_in_hs     = in_valid_i && (state_q == ST_LOAD);
    assign w_out_hs    = out_ready_i && (state_q == ST_DRAIN);
    assign w_load_done = w_in_hs && (wr_q == LAST_IDX);
    assign w_sort_done = (state_q == ST_SORT) && (p_q == LAST_CMP) && (i_q == LAST_CMP);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_LOAD;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (w_load_done) state_d = ST_SORT;
            ST_SORT:  if (w_sort_done) state_d = ST_DRAIN;
            ST_DRAIN: if (w_out_hs && (rd_q == LAST_IDX)) state_d = ST_LOAD;
            default:  state_d = ST_LOAD;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            wr_q <= '0;
            rd_q <= '0;
            p_q  <= '0;
            i_q  <= '0;
        end else begin
            if (w_in_hs) begin
                mem_q[wr_q] <= in_data_i;
                wr_q        <= (wr_q == LAST_IDX) ? '0 : wr_q + 1'b1;
            end
            if (state_q == ST_SORT) begin
                if (w_swap) begin
                    mem_q[i_q]     <= w_b;
                    mem_q[w_i_nxt] <= w_a;
                end
                // Inner index wraps each pass; pass counter wraps after the last pass.
                if (i_q == LAST_CMP) begin
                    i_q <= '0;
                    p_q <= (p_q == LAST_CMP) ? '0 : p_q + 1'b1;
                end else begin
                    i_q <= w_i_nxt;
                end
            end
            if (w_out_hs) begin
                rd_q <= (rd_q == LAST_IDX) ? '0 : rd_q + 1'b1;
            end
        end
    end

    // ---------------- Outputs ----------------
    assign in_ready_o  = (state_q == ST_LOAD);
    assign out_valid_o = (state_q == ST_DRAIN);
    assign out_data_o  = (state_q == ST_DRAIN) ? mem_q[rd_q] : '0;
    assign out_last_o  = (state_q == ST_DRAIN) && (rd_q == LAST_IDX);
    assign busy_o      = (state_q == ST_SORT) || (state_q == ST_DRAIN);

`ifdef SORT_SWAP_COUNT_EN
    logic [7:0] swap_cnt_q;

    // Cleared on the edge that enters SORT; held until the next sort starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 swap_cnt_q <= '0;
        else if (w_load_done)                       swap_cnt_q <= '0;
        else if (w_swap && (swap_cnt_q != 8'hFF))   swap_cnt_q <= swap_cnt_q + 8'd1;
    end

    assign swap_count_o = swap_cnt_q;
`endif

endmodule : nibble_sort_ctrl
`default_nettype wire
